audio_dsm_output: RTL and testbench

//  Multi-channel 1-bit audio DAC front end, successor to the single-channel PWM output.

---
 rtl/audio_dsm_output.sv | 102 ++++++++++
 tb/tb_audio_dsm_output.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/audio_dsm_output.sv
// audio_dsm_output: multi-channel 1-bit audio DAC front end (frame FIFO, rate divider, PWM / delta-sigma)
module audio_dsm_output #(
   parameter int CHANNELS     = 2,
   parameter int SAMPLE_WIDTH = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int DIV_WIDTH    = 16
) (
   input  logic                                 i_clock,
   input  logic                                 i_reset_n,
   input  logic                                 i_enable,
   input  logic                                 i_mode,
   input  logic [31:0]                          i_reload,
   input  logic                                 i_valid,
   output logic                                 o_ready,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0]     i_sample,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_level,
   output logic                                 o_underrun,
   output logic [CHANNELS-1:0]                  o_pwm
);
   localparam int SW = SAMPLE_WIDTH;
   localparam int FW = CHANNELS * SW;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   logic [FW-1:0]        mem [FIFO_DEPTH];
   logic [FW-1:0]        head;
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        level_nxt;
   logic                 push, pop, empty, tick, en_q;
   logic [DIV_WIDTH-1:0] div, div_cur, reload;
   logic [SW-1:0]        pcnt, rev_cnt;
   logic [SW-1:0]        cur_u [CHANNELS];
   logic [SW:0]          acc   [CHANNELS];
   logic [SW:0]          sum   [CHANNELS];

   // handshake, divider view and modulator arithmetic; while the divider was idle last
   // clock it is treated as freshly loaded with i_reload, so the first tick lands reload+1 clocks after enable
   always_comb begin
      reload    = i_reload[DIV_WIDTH-1:0];
      div_cur   = en_q ? div : reload;
      tick      = i_enable && (div_cur == '0);
      empty     = (o_level == '0);
      push      = i_valid && o_ready;
      pop       = tick && !empty;
      level_nxt = o_level + LW'(push) - LW'(pop);
      head      = mem[rd_ptr];
      for (int i = 0; i < SW; i++) rev_cnt[i] = pcnt[SW-1-i];
      for (int c = 0; c < CHANNELS; c++) sum[c] = {1'b0, acc[c][SW-1:0]} + {1'b0, cur_u[c]};
   end

   // sample-rate divider: counts down while enabled, reloads on tick, tracks i_reload while idle
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         div  <= '0;
         en_q <= 1'b0;
      end else begin
         en_q <= i_enable;
         div  <= (!i_enable || div_cur == '0) ? reload : div_cur - 1'b1;
      end
   end

   // frame storage; data needs no reset because level gates every read
   always_ff @(posedge i_clock) begin
      if (push) mem[wr_ptr] <= i_sample;
   end

   // FIFO pointers, level, registered ready and underrun pulse
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_level    <= '0;
         o_ready    <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
         o_level    <= level_nxt;
         o_ready    <= level_nxt != LW'(FIFO_DEPTH);
         o_underrun <= tick && empty;
      end
   end

   // playback: current samples in offset binary, PWM counter, delta-sigma accumulators, outputs
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pcnt  <= '0;
         o_pwm <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            cur_u[c] <= {1'b1, {(SW-1){1'b0}}};
            acc[c]   <= '0;
         end
      end else begin
         pcnt <= i_enable ? pcnt + 1'b1 : pcnt;
         for (int c = 0; c < CHANNELS; c++) begin
            if (pop) cur_u[c] <= {~head[c*SW+SW-1], head[c*SW +: SW-1]};
            acc[c]   <= (i_enable && i_mode) ? sum[c] : '0;
            o_pwm[c] <= !i_enable ? 1'b0 : i_mode ? sum[c][SW] : (cur_u[c] >= rev_cnt);
         end
      end
   end
endmodule

// File: tb/tb_audio_dsm_output.sv
// tb_audio_dsm_output: directed vector bench for the audio DAC front end
module tb_audio_dsm_output;
   logic        i_clock = 1'b0;
   logic        i_reset_n, i_enable, i_mode, i_valid;
   logic [31:0] i_reload;
   logic [31:0] i_sample;
   logic        o_ready, o_underrun;
   logic [3:0]  o_level;
   logic [1:0]  o_pwm;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int         cyc;
      logic [3:0] lvl;
      logic       und;
      logic       rdy;
   } vec_t;
   vec_t vt[9];

   audio_dsm_output dut (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_mode(i_mode),
      .i_reload(i_reload), .i_valid(i_valid), .o_ready(o_ready), .i_sample(i_sample),
      .o_level(o_level), .o_underrun(o_underrun), .o_pwm(o_pwm)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0;
      i_enable  = 1'b0;
      i_mode    = 1'b0;
      i_valid   = 1'b0;
      i_reload  = 32'd0;
      i_sample  = 32'd0;
      repeat (2) @(negedge i_clock);
      i_reset_n = 1'b1;
      @(negedge i_clock);
   endtask

   task automatic push(input logic [31:0] frame);
      i_valid  = 1'b1;
      i_sample = frame;
      @(negedge i_clock);
      i_valid  = 1'b0;
   endtask

   task automatic count_ones(input int n, output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge i_clock);
         c0 += int'(o_pwm[0]);
         c1 += int'(o_pwm[1]);
      end
   endtask

   initial begin
      int edges, c0, c1;
      vt[0] = '{9,  4'd3, 1'b0, 1'b1};
      vt[1] = '{10, 4'd2, 1'b0, 1'b1};
      vt[2] = '{19, 4'd2, 1'b0, 1'b1};
      vt[3] = '{20, 4'd1, 1'b0, 1'b1};
      vt[4] = '{29, 4'd1, 1'b0, 1'b1};
      vt[5] = '{30, 4'd0, 1'b0, 1'b1};
      vt[6] = '{39, 4'd0, 1'b0, 1'b1};
      vt[7] = '{40, 4'd0, 1'b1, 1'b1};
      vt[8] = '{41, 4'd0, 1'b0, 1'b1};

      // reset state and three-frame playback at reload 9
      do_reset();
      chk("rst_level", 32'(o_level), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_underrun", 32'(o_underrun), 32'd0);
      chk("rst_pwm", 32'(o_pwm), 32'd0);
      i_reload = 32'd9;
      push(32'h0000_1000);
      push(32'h0000_2000);
      push(32'h0000_3000);
      chk("t1_level3", 32'(o_level), 32'd3);
      i_enable = 1'b1;
      edges = 0;
      foreach (vt[k]) begin
         repeat (vt[k].cyc - edges) @(negedge i_clock);
         edges = vt[k].cyc;
         chk($sformatf("t1_lvl@%0d", vt[k].cyc), 32'(o_level), 32'(vt[k].lvl));
         chk($sformatf("t1_und@%0d", vt[k].cyc), 32'(o_underrun), 32'(vt[k].und));
         chk($sformatf("t1_rdy@%0d", vt[k].cyc), 32'(o_ready), 32'(vt[k].rdy));
      end

      // fill to full while disabled; ninth frame ignored; pop does not open a same-cycle slot
      do_reset();
      i_valid  = 1'b1;
      i_sample = 32'h1234_5678;
      repeat (9) @(negedge i_clock);
      chk("t2_level_full", 32'(o_level), 32'd8);
      chk("t2_ready_full", 32'(o_ready), 32'd0);
      i_enable = 1'b1;
      i_reload = 32'd0;
      @(negedge i_clock);
      i_enable = 1'b0;
      chk("t2_level_pop", 32'(o_level), 32'd7);
      chk("t2_ready_pop", 32'(o_ready), 32'd1);
      @(negedge i_clock);
      i_valid = 1'b0;
      chk("t2_level_refill", 32'(o_level), 32'd8);
      chk("t2_ready_refill", 32'(o_ready), 32'd0);

      // delta-sigma densities: u=0x8000 -> half, u=0xFFFF -> all ones in a short window
      do_reset();
      push(32'h7FFF_0000);
      i_enable = 1'b1;
      i_mode   = 1'b1;
      @(negedge i_clock);
      i_reload = 32'd60000;
      chk("t3_level_popped", 32'(o_level), 32'd0);
      repeat (4) @(negedge i_clock);
      count_ones(1000, c0, c1);
      chk("t3_dsm_half", 32'(c0), 32'd500);
      chk("t3_dsm_full", 32'(c1), 32'd1000);

      // PWM: u=0 high only when the counter is 0; u=0xFFFF always high; u=0xC000 three quarters
      do_reset();
      push(32'h7FFF_8000);
      i_enable = 1'b1;
      @(negedge i_clock);
      i_reload = 32'd60000;
      chk("t4_first_edge", 32'(o_pwm), 32'd3);
      count_ones(3000, c0, c1);
      chk("t4_pwm_zero", 32'(c0), 32'd0);
      chk("t4_pwm_full", 32'(c1), 32'd3000);
      push(32'h7FFF_4000);
      i_enable = 1'b0;
      @(negedge i_clock);
      chk("t4_disable_low", 32'(o_pwm), 32'd0);
      chk("t4_disable_keep", 32'(o_level), 32'd1);
      i_enable = 1'b1;
      i_reload = 32'd0;
      @(negedge i_clock);
      i_reload = 32'd60000;
      chk("t4_second_pop", 32'(o_level), 32'd0);
      repeat (4) @(negedge i_clock);
      count_ones(1000, c0, c1);
      chk("t4_pwm_3q", 32'(c0), 32'd750);
      chk("t4_pwm_full2", 32'(c1), 32'd1000);

      // push into an empty FIFO in a tick cycle: underrun, frame plays on the next tick
      do_reset();
      i_reload = 32'd4;
      i_enable = 1'b1;
      repeat (9) @(negedge i_clock);
      i_valid  = 1'b1;
      i_sample = 32'h0000_7FFF;
      @(negedge i_clock);
      i_valid = 1'b0;
      chk("t5_underrun", 32'(o_underrun), 32'd1);
      chk("t5_level1", 32'(o_level), 32'd1);
      repeat (4) @(negedge i_clock);
      chk("t5_level_hold", 32'(o_level), 32'd1);
      chk("t5_und_low", 32'(o_underrun), 32'd0);
      @(negedge i_clock);
      chk("t5_level0", 32'(o_level), 32'd0);
      chk("t5_no_und", 32'(o_underrun), 32'd0);
      count_ones(3, c0, c1);
      chk("t5_played", 32'(c0), 32'd3);

      // asynchronous reset mid-playback with five frames queued
      do_reset();
      i_reload = 32'd1000;
      i_enable = 1'b1;
      for (int f = 0; f < 5; f++) push(32'h0000_7FFF);
      chk("t6_level5", 32'(o_level), 32'd5);
      #2 i_reset_n = 1'b0;
      #1;
      chk("t6_rst_level", 32'(o_level), 32'd0);
      chk("t6_rst_pwm", 32'(o_pwm), 32'd0);
      chk("t6_rst_und", 32'(o_underrun), 32'd0);
      @(negedge i_clock);
      i_enable  = 1'b0;
      i_reset_n = 1'b1;
      @(negedge i_clock);
      chk("t6_ready", 32'(o_ready), 32'd1);
      chk("t6_level_after", 32'(o_level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
